nf10_input_arbiter_rr: RTL and testbench
========================================

Name: nf10_input_arbiter_rr

Overview:
- Parametrised successor of the 5-port datapath input arbiter.
- Merges NUM_PORTS AXI4-Stream slave ports into one master stream, packet-atomic. Packets from different ports are never interleaved.
- Each port has its own input FIFO, which absorbs back-pressure.
- A round-robin scheduler picks the next port with a packet waiting.
- Sits at the head of the user datapath, in front of output-port lookup.

Parameters:
- NUM_PORTS, 5: number of slave ports, 2..16.
- C_M_AXIS_DATA_WIDTH, 256: tdata width. tstrb width is C_M_AXIS_DATA_WIDTH/8.
- C_M_AXIS_TUSER_WIDTH, 128: tuser width.
- FIFO_DEPTH_LOG2, 3: per-port FIFO depth is 2**FIFO_DEPTH_LOG2 beats, range 2..10.

Ports:
- axi_aclk  in  1  Sole clock.
- axi_resetn  in  1  Asynchronous, active-low reset.
- s_axis_tdata  in  NUM_PORTS*DW  Port i occupies slice [i*DW +: DW].
- s_axis_tstrb  in  NUM_PORTS*DW/8  Per-port tstrb, packed the same way.
- s_axis_tuser  in  NUM_PORTS*UW  Per-port tuser, packed the same way.
- s_axis_tvalid  in  NUM_PORTS  Per-port valid.
- s_axis_tready  out  NUM_PORTS  Per-port ready.
- s_axis_tlast  in  NUM_PORTS  Per-port last.
- m_axis_tdata  out  DW  Merged data.
- m_axis_tstrb  out  DW/8  Merged tstrb.
- m_axis_tuser  out  UW  Merged tuser.
- m_axis_tvalid  out  1  Merged valid.
- m_axis_tready  in  1  Downstream ready.
- m_axis_tlast  out  1  Merged last.

Behaviour:
- Reset:
  - Reset is axi_resetn low, applied asynchronously. It has the same effect mid-packet.
  - While reset is held, all FIFOs are empty and s_axis_tready = 0.
  - m_axis_tvalid = 0 and m_axis_tlast = 0.
  - m_axis_tdata, m_axis_tstrb and m_axis_tuser = 0.
  - State = IDLE and rr_ptr = NUM_PORTS-1, so port 0 is first in order.
- Input FIFOs:
  - s_axis_tready[i] = !full[i]. It is registered-equivalent, with no combinational path from any tvalid.
  - A beat is written when tvalid[i] & tready[i]. It is visible at the FIFO head on the next cycle.
  - Each entry holds {tlast, tuser, tstrb, tdata}.
  - A write and a read on the same cycle are both allowed when full, so occupancy is unchanged.
- Scheduler FSM:
  - States are IDLE and XFER.
  - IDLE: scan ports starting at rr_ptr+1 and wrapping modulo NUM_PORTS.
    - The first port with !empty is latched into grant; rr_ptr <= grant; go to XFER.
    - If every FIFO is empty, stay in IDLE.
  - XFER: m_axis_* mirrors the head of FIFO[grant]; m_axis_tvalid = !empty[grant].
    - A pop happens on m_axis_tvalid & m_axis_tready.
    - A pop with tlast = 1 returns to IDLE.
    - If FIFO[grant] runs empty mid-packet, tvalid deasserts and grant is held. No other port is served.
- Latency and throughput:
  - Minimum latency is 2 cycles from an s-side handshake to m_axis_tvalid: 1 cycle FIFO write, 1 cycle IDLE grant.
  - Exactly one bubble cycle (IDLE) separates consecutive packets.
  - Within a packet, throughput is 1 beat/cycle.
- AXI-Stream rules:
  - Once asserted, m_axis_tvalid and the payload stay stable until m_axis_tready.
  - Stalling m_axis_tready never drops or duplicates beats.
- A single-beat packet (tlast on its first beat) occupies one XFER cycle.

Optional Feature:
- Macro: NF10_INPUT_ARBITER_PKT_CNT_EN.
- When defined:
  - Adds output port pkt_cnt, NUM_PORTS*32 bits wide: one counter per port.
  - A counter increments on each pop with tlast = 1 from that port and wraps at 2**32.
  - Counters reset to 0.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package nf10_input_arbiter_pkg holds:
  - localparam functions clog2 and the FIFO entry width (1 + UW + DW/8 + DW);
  - state encoding IDLE = 1'b0, XFER = 1'b1.
- One natural sub-module: nf10_arb_fallthrough_fifo.
  - It is a first-word-fall-through FIFO with ports din, wr_en, full, dout, rd_en and empty.
  - It is instantiated NUM_PORTS times in a generate loop.

Test Plan:
- Reset, then a single 3-beat packet on port 2 with m_axis_tready = 1:
  - m_axis_tvalid rises 2 cycles after the first handshake;
  - 3 beats appear with tlast on the third; data and tuser match.
- Ports 0, 1 and 4 each hold one 2-beat packet, all offered simultaneously:
  - output order is 0, 1, 4;
  - there is no interleaving and exactly one idle cycle between packets.
- Port 3 sends 10 beats with m_axis_tready = 0 and depth 8:
  - s_axis_tready[3] drops after 8 accepted beats;
  - releasing m_axis_tready drains all 10 beats in order.
- Port 1 pauses tvalid mid-packet while port 0 has data:
  - m_axis_tvalid deasserts and the grant stays on 1 until its tlast;
  - port 0 is served next.
- Reset is asserted mid-packet on port 2:
  - all outputs are 0 immediately (asynchronously);
  - after release a fresh packet on port 0 is served first.
- With NF10_INPUT_ARBITER_PKT_CNT_EN, send 5 packets on port 4 and 2 on port 0:
  - pkt_cnt slice 4 = 5, slice 0 = 2, all other slices 0.

Source files
------------

// File: rtl/nf10_input_arbiter_pkg.sv
// Shared types and elaboration-time helpers for the round-robin input arbiter.
package nf10_input_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // One FIFO entry carries {tlast, tuser, tstrb, tdata}.
  function automatic int fifo_entry_w(input int dw, input int uw);
    return 1 + uw + dw / 8 + dw;
  endfunction

endpackage

// File: rtl/nf10_arb_fallthrough_fifo.sv
// First-word-fall-through FIFO: the oldest entry is always presented on dout.
module nf10_arb_fallthrough_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  input  logic             rd_en,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_wr;
  logic                  do_rd;

  assign empty = (count == '0);
  assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign dout  = mem[rd_ptr];
  assign do_rd = rd_en & ~empty;
  // A read on the same cycle frees the slot, so a full FIFO may still take a write.
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nf10_input_arbiter_rr.sv
// Packet-atomic round-robin merge of NUM_PORTS AXI4-Stream inputs into one stream.
// Optional per-port packet counters: define NF10_INPUT_ARBITER_PKT_CNT_EN.
module nf10_input_arbiter_rr
  import nf10_input_arbiter_pkg::*;
#(
  parameter int NUM_PORTS            = 5,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH_LOG2      = 3
) (
  input  logic                                      axi_aclk,
  input  logic                                      axi_resetn,
  input  logic [NUM_PORTS*C_M_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*C_M_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_PORTS*C_M_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                      s_axis_tready,
  input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]          m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast
`ifdef NF10_INPUT_ARBITER_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]                   pkt_cnt
`endif
);

  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;
  localparam int SW = DW / 8;
  localparam int EW = fifo_entry_w(DW, UW);
  localparam int PW = clog2(NUM_PORTS);

  logic [EW-1:0]        fifo_dout [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] fifo_wr;
  logic [NUM_PORTS-1:0] fifo_rd;
  logic                 in_en;
  arb_state_t           state;
  logic [PW-1:0]        grant;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        next_port;
  logic [PW-1:0]        cand;
  logic                 found;
  logic [EW-1:0]        head;
  logic                 head_last;
  logic                 xfer;
  logic                 pop;

  // Inputs stay closed while reset is held and open on the first clock after release.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) in_en <= 1'b0;
    else             in_en <= 1'b1;
  end

  assign s_axis_tready = ~fifo_full & {NUM_PORTS{in_en}};
  assign fifo_wr       = s_axis_tvalid & s_axis_tready;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    nf10_arb_fallthrough_fifo #(
      .WIDTH      (EW),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk   (axi_aclk),
      .rst_n (axi_resetn),
      .din   ({s_axis_tlast[i], s_axis_tuser[i*UW +: UW],
               s_axis_tstrb[i*SW +: SW], s_axis_tdata[i*DW +: DW]}),
      .wr_en (fifo_wr[i]),
      .full  (fifo_full[i]),
      .dout  (fifo_dout[i]),
      .rd_en (fifo_rd[i]),
      .empty (fifo_empty[i])
    );
  end

  // Search starts one past the last granted port so every port gets a turn.
  always_comb begin
    found     = 1'b0;
    next_port = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!found && !fifo_empty[cand]) begin
        found     = 1'b1;
        next_port = cand;
      end
    end
  end

  assign xfer          = (state == XFER);
  assign head          = fifo_dout[grant];
  assign head_last     = head[EW-1];
  assign m_axis_tvalid = xfer & ~fifo_empty[grant];
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = xfer ? head : '0;

  always_comb begin
    fifo_rd        = '0;
    fifo_rd[grant] = pop;
  end

  // Grant is held for the whole packet, even if its FIFO underruns mid-packet.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= PW'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant  <= next_port;
            rr_ptr <= next_port;
            state  <= XFER;
          end
        end
        XFER: begin
          if (pop && head_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NF10_INPUT_ARBITER_PKT_CNT_EN
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pop && head_last && (grant == PW'(i)))
          pkt_cnt[i*32 +: 32] <= pkt_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nf10_input_arbiter_rr.sv
// Scoreboard bench for nf10_input_arbiter_rr: per-port expected queues and a round-robin reference.
// Covers the NF10_INPUT_ARBITER_PKT_CNT_EN counters when that macro is defined.
module tb_nf10_input_arbiter_rr;

  localparam int NP  = 5;
  localparam int DW  = 64;
  localparam int UW  = 32;
  localparam int SW  = DW / 8;
  localparam int FDL = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [SW-1:0] strb;
    logic          last;
    int            pre_gap;
    int            acc;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*SW-1:0]  s_tstrb;
  logic [NP*UW-1:0]  s_tuser;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tready;
  logic [NP-1:0]     s_tlast;
  logic [DW-1:0]     m_tdata;
  logic [SW-1:0]     m_tstrb;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
`ifdef NF10_INPUT_ARBITER_PKT_CNT_EN
  logic [NP*32-1:0]  pkt_cnt;
`endif

  nf10_input_arbiter_rr #(
    .NUM_PORTS            (NP),
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .FIFO_DEPTH_LOG2      (FDL)
  ) dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
`ifdef NF10_INPUT_ARBITER_PKT_CNT_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t tx_q   [NP][$];
  beat_t port_q [NP][$];
  int    start_order [$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    rr = NP - 1;
  int    cur = 0;
  int    last_end = -10;
  bit    in_pkt = 1'b0;
  int    ready_mode = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: condition false, required true", nm);
  endtask

  function automatic beat_t mk(input logic last, input int gap);
    beat_t b;
    b.data    = {$urandom(), $urandom()};
    b.user    = $urandom();
    b.strb    = SW'($urandom());
    b.last    = last;
    b.pre_gap = gap;
    b.acc     = 0;
    return b;
  endfunction

  task automatic send_pkt(input int port, input int len, input int gap_max);
    for (int b = 0; b < len; b++)
      tx_q[port].push_back(mk(b == len - 1, (gap_max > 0) ? $urandom_range(0, gap_max) : 0));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int t = 0; t < limit && !done; t++) begin
      @(negedge clk);
      done = !in_pkt && !m_tvalid;
      for (int i = 0; i < NP; i++)
        if (tx_q[i].size() != 0 || port_q[i].size() != 0) done = 1'b0;
    end
    if (!done) fail("drain_timeout");
  endtask

  // Stimulus driver: presents the head of each port's queue, honouring idle gaps.
  initial begin
    s_tvalid = '0; s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tlast = '0;
    m_tready = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        s_tvalid[i] = 1'b0;
        if (tx_q[i].size() > 0) begin
          if (tx_q[i][0].pre_gap > 0) begin
            tx_q[i][0].pre_gap = tx_q[i][0].pre_gap - 1;
          end else begin
            s_tvalid[i]          = 1'b1;
            s_tdata[i*DW +: DW]  = tx_q[i][0].data;
            s_tuser[i*UW +: UW]  = tx_q[i][0].user;
            s_tstrb[i*SW +: SW]  = tx_q[i][0].strb;
            s_tlast[i]           = tx_q[i][0].last;
          end
        end
      end
      case (ready_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model and monitor: accepted beats queue per port; packets are expected
  // in round-robin order among ports holding data, one cycle after the previous tlast.
  initial begin
    int    g, g_exp, exp_p, min_acc, p;
    beat_t b;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < NP; i++) port_q[i].delete();
        rr = NP - 1; in_pkt = 1'b0; last_end = -10;
      end else begin
        for (int i = 0; i < NP; i++) begin
          if (s_tvalid[i] && s_tready[i] && tx_q[i].size() > 0) begin
            b = tx_q[i].pop_front();
            b.acc = cyc;
            port_q[i].push_back(b);
          end
        end
        if (m_tvalid) begin
          if (!in_pkt) begin
            g = cyc - 1; exp_p = -1; min_acc = 1 << 30;
            for (int k = 1; k <= NP; k++) begin
              p = (rr + k) % NP;
              if (port_q[p].size() > 0) begin
                if (port_q[p][0].acc < min_acc) min_acc = port_q[p][0].acc;
                if (exp_p < 0 && port_q[p][0].acc <= g - 1) exp_p = p;
              end
            end
            g_exp = (last_end + 1 > min_acc + 1) ? last_end + 1 : min_acc + 1;
            chk("start_edge", 64'(g), 64'(g_exp));
            if (exp_p < 0) begin
              fail("grant_has_data");
              exp_p = 0;
            end
            cur = exp_p; rr = exp_p; in_pkt = 1'b1;
            start_order.push_back(exp_p);
          end
          if (m_tready) begin
            if (port_q[cur].size() == 0) begin
              fail("pop_expected_beat");
            end else begin
              b = port_q[cur].pop_front();
              chk("beat_data", m_tdata, b.data);
              chk("beat_user", 64'(m_tuser), 64'(b.user));
              chk("beat_strb", 64'(m_tstrb), 64'(b.strb));
              chk("beat_last", 64'(m_tlast), 64'(b.last));
              if (b.last) begin
                in_pkt = 1'b0;
                last_end = cyc;
              end
            end
          end
        end else if (in_pkt && port_q[cur].size() > 0 && port_q[cur][0].acc <= cyc - 1) begin
          fail("tvalid_while_data");
        end
      end
      cyc++;
    end
  end

  initial begin
    rst_n = 1'b0;
    cycles(4);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast",  64'(m_tlast),  64'd0);
    chk("rst_tdata",  m_tdata,       64'd0);
    chk("rst_tuser",  64'(m_tuser),  64'd0);
    chk("rst_tstrb",  64'(m_tstrb),  64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    rst_n = 1'b1;
    cycles(2);

    // Single 3-beat packet on port 2, then a single-beat packet on port 4.
    ready_mode = 1;
    send_pkt(2, 3, 0);
    wait_idle(100);
    send_pkt(4, 1, 0);
    wait_idle(100);

    // Simultaneous 2-beat packets on ports 0, 1, 4.
    start_order.delete();
    send_pkt(0, 2, 0); send_pkt(1, 2, 0); send_pkt(4, 2, 0);
    wait_idle(200);
    chk("order_len", 64'(start_order.size()), 64'd3);
    if (start_order.size() == 3) begin
      chk("order_0", 64'(start_order[0]), 64'd0);
      chk("order_1", 64'(start_order[1]), 64'd1);
      chk("order_2", 64'(start_order[2]), 64'd4);
    end

    // Back-pressure: 10 beats into the depth-8 FIFO of port 3.
    ready_mode = 0;
    send_pkt(3, 10, 0);
    cycles(16);
    chk("bp_tready3",  64'(s_tready[3]),       64'd0);
    chk("bp_accepted", 64'(port_q[3].size()),  64'd8);
    chk("bp_waiting",  64'(tx_q[3].size()),    64'd2);
    ready_mode = 1;
    wait_idle(200);

    // Port 1 stalls mid-packet while port 0 has a packet waiting.
    start_order.delete();
    tx_q[1].push_back(mk(1'b0, 0));
    tx_q[1].push_back(mk(1'b0, 0));
    tx_q[1].push_back(mk(1'b1, 5));
    cycles(3);
    send_pkt(0, 2, 0);
    wait_idle(200);
    chk("pause_len", 64'(start_order.size()), 64'd2);
    if (start_order.size() == 2) begin
      chk("pause_first",  64'(start_order[0]), 64'd1);
      chk("pause_second", 64'(start_order[1]), 64'd0);
    end

    // Asynchronous reset in the middle of a port-2 packet.
    send_pkt(2, 6, 0);
    cycles(6);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 64'(m_tvalid), 64'd0);
    chk("arst_tlast",  64'(m_tlast),  64'd0);
    chk("arst_tdata",  m_tdata,       64'd0);
    chk("arst_tuser",  64'(m_tuser),  64'd0);
    chk("arst_tready", 64'(s_tready), 64'd0);
    for (int i = 0; i < NP; i++) tx_q[i].delete();
    cycles(3);
    rst_n = 1'b1;
    start_order.delete();
    for (int k = 0; k < 2; k++) send_pkt(0, $urandom_range(1, 3), 0);
    for (int k = 0; k < 5; k++) send_pkt(4, $urandom_range(1, 3), 0);
    wait_idle(400);
    chk("post_rst_first", 64'(start_order.size() > 0 ? start_order[0] : -1), 64'd0);
`ifdef NF10_INPUT_ARBITER_PKT_CNT_EN
    chk("pkt_cnt_0", 64'(pkt_cnt[0*32 +: 32]), 64'd2);
    chk("pkt_cnt_4", 64'(pkt_cnt[4*32 +: 32]), 64'd5);
    for (int i = 1; i < 4; i++) chk("pkt_cnt_other", 64'(pkt_cnt[i*32 +: 32]), 64'd0);
`endif

    // Randomised traffic with random gaps and random downstream back-pressure.
    for (int batch = 0; batch < 24; batch++) begin
      ready_mode = (batch % 3 == 0) ? 1 : 2;
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          int npk;
          npk = $urandom_range(1, 2);
          for (int k = 0; k < npk; k++) send_pkt(i, $urandom_range(1, 6), $urandom_range(0, 2));
        end
      end
      wait_idle(3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
